bram_sample_streamer: RTL

// Reads 32-bit words back out of the shared sample BRAM that bram_wrapper fills, at a fixed audio rate.

---
 rtl/bram_sample_streamer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bram_sample_streamer.sv
// bram_sample_streamer: paces reads out of the shared sample BRAM at a fixed
// audio rate and hands each word to the synth datapath on a valid/ready stream.
// Read-only on the BRAM's second port.
// Optional feature: define BRAM_STREAM_TLAST_EN to add a sample_tlast output
// that marks the sample fetched from the last BRAM word.
module bram_sample_streamer #(
    parameter int BRAM_DEPTH     = 2048,
    parameter int DATA_W         = 32,
    parameter int CLK_MHZ        = 100,
    parameter int SAMPLE_RATE_HZ = 48000,
    parameter int READ_LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              restart,
    output logic [31:0]       BRAM_addr,
    output logic              BRAM_clk,
    output logic [31:0]       BRAM_din,
    input  logic [31:0]       BRAM_dout,
    output logic              BRAM_en,
    output logic              BRAM_rst,
    output logic [3:0]        BRAM_we,
    output logic [DATA_W-1:0] sample_tdata,
    output logic              sample_tvalid,
    input  logic              sample_tready,
    output logic              wrap_pulse,
`ifdef BRAM_STREAM_TLAST_EN
    output logic              sample_tlast,
`endif
    output logic [15:0]       overrun_cnt
);

    localparam int DIV   = (CLK_MHZ * 1_000_000) / SAMPLE_RATE_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BRAM_DEPTH - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    // A tick period shorter than one full fetch would make every tick overrun.
    if (DIV < READ_LATENCY + 3) begin : g_div_check
        $error("bram_sample_streamer: DIV=%0d is smaller than READ_LATENCY+3", DIV);
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  tickCnt_q;
    logic [CNT_W-1:0]  tickCnt_d;
    logic [IDX_W-1:0]  index_q;
    logic [LAT_W-1:0]  waitCnt_q;
    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              wrap_q;
    logic [15:0]       overrun_q;
    logic              tick;
    logic              overrunHit;
    logic              captureNow;

    // Sample-rate divider: counts while enabled, parks at zero otherwise.
    always_comb begin
        tick      = 1'b0;
        tickCnt_d = '0;
        if (enable) begin
            if (tickCnt_q == DIV_LAST) begin
                tick = 1'b1;
            end else begin
                tickCnt_d = tickCnt_q + CNT_W'(1);
            end
        end
    end

    // A tick is lost whenever the fetch path is busy or the last sample is still unaccepted.
    assign overrunHit = tick && ((state_q == ST_READ) || (state_q == ST_WAIT) ||
                                 ((state_q == ST_HOLD) && !sample_tready));

    assign captureNow = (state_q == ST_WAIT) && (waitCnt_q == LAT_LAST);

    // Fetch FSM plus all registered stream outputs, index and overrun bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tickCnt_q <= '0;
            index_q   <= '0;
            waitCnt_q <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            wrap_q    <= 1'b0;
            overrun_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
            wrap_q    <= 1'b0;
            if (overrunHit && (overrun_q != 16'hFFFF)) begin
                overrun_q <= overrun_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (restart) begin
                        index_q <= '0;
                    end
                    if (tick) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    waitCnt_q <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (captureNow) begin
                        tdata_q  <= BRAM_dout[DATA_W-1:0];
                        tvalid_q <= 1'b1;
                        state_q  <= ST_HOLD;
                    end else begin
                        waitCnt_q <= waitCnt_q + LAT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (sample_tready) begin
                        tvalid_q <= 1'b0;
                        if (restart) begin
                            index_q <= '0;
                        end else if (index_q == IDX_LAST) begin
                            index_q <= '0;
                            wrap_q  <= 1'b1;
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                        end
                        state_q <= tick ? ST_READ : ST_IDLE;
                    end else if (restart) begin
                        index_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BRAM_STREAM_TLAST_EN
    logic tlast_q;

    // Last-word marker captured together with tdata and held with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tlast_q <= 1'b0;
        end else if (captureNow) begin
            tlast_q <= (index_q == IDX_LAST);
        end
    end

    assign sample_tlast = tlast_q;
`endif

    assign BRAM_addr     = {{(32 - IDX_W - 2){1'b0}}, index_q, 2'b00};
    assign BRAM_clk      = clk;
    assign BRAM_din      = '0;
    assign BRAM_en       = (state_q == ST_READ) || (state_q == ST_WAIT);
    assign BRAM_rst      = ~rst_n;
    assign BRAM_we       = 4'b0000;
    assign sample_tdata  = tdata_q;
    assign sample_tvalid = tvalid_q;
    assign wrap_pulse    = wrap_q;
    assign overrun_cnt   = overrun_q;

endmodule
